// File: rtl/fifo_rd_ctrl.sv
// rtl/fifo_rd_ctrl.sv - FIFO read controller feeding a 2-entry output stream buffer.
// Optional underflow counter enabled by defining FIFO_RD_ERR_CNT_EN.
module fifo_rd_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] data_out,
    input  logic                  pop_err_on_empty,
    output logic                  pop,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  word_cnt,
    output logic [CNT_WIDTH-1:0]  err_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [1:0]            occ;
    logic                  inflight;
    logic [DATA_WIDTH-1:0] head_q;
    logic [DATA_WIDTH-1:0] tail_q;
    logic                  xfer;
    logic                  capture;
    logic [2:0]            committed;

    assign xfer    = m_valid & m_ready;
    assign capture = inflight;

    // A word leaving this cycle frees its slot, so a pop may replace it back-to-back.
    assign committed = {1'b0, occ} + {2'b0, inflight} - {2'b0, xfer};

    assign pop     = !rst && (state == RUN) && en && !empty && (committed < 3'd2);
    assign m_valid = !rst && (occ != 2'd0);
    assign m_data  = head_q;
    assign busy    = !rst && (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en) state_nxt = RUN;
            RUN:     if (!en) state_nxt = DRAIN;
            DRAIN: begin
                if (en)
                    state_nxt = RUN;
                else if (!inflight && (occ == 2'd0))
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            occ      <= 2'd0;
            inflight <= 1'b0;
            word_cnt <= '0;
        end else begin
            state    <= state_nxt;
            inflight <= pop;
            if (xfer)
                word_cnt <= word_cnt + CNT_WIDTH'(1);
            case ({capture, xfer})
                2'b01:   occ <= occ - 2'd1;
                2'b10:   occ <= occ + 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    // Data slots carry no reset; m_valid qualifies them.
    always_ff @(posedge clk) begin
        case ({capture, xfer})
            2'b01: head_q <= tail_q;
            2'b10: begin
                if (occ == 2'd0)
                    head_q <= data_out;
                else
                    tail_q <= data_out;
            end
            2'b11: begin
                if (occ == 2'd1) begin
                    head_q <= data_out;
                end else begin
                    head_q <= tail_q;
                    tail_q <= data_out;
                end
            end
            default: ;
        endcase
    end

`ifdef FIFO_RD_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            err_cnt <= '0;
        else if (pop_err_on_empty && (err_cnt != '1))
            err_cnt <= err_cnt + CNT_WIDTH'(1);
    end
`else
    logic unused_pop_err;
    assign unused_pop_err = pop_err_on_empty;
    assign err_cnt        = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb/tb_fifo_rd_ctrl.sv - scoreboard bench for fifo_rd_ctrl with a 1-cycle-latency FIFO model.
`timescale 1ns/1ps
module tb_fifo_rd_ctrl;
    localparam int DW = 8;
    localparam int CW = 16;
`ifdef FIFO_RD_ERR_CNT_EN
    localparam int EXP_ERR = 3;
`else
    localparam int EXP_ERR = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          pop_err_on_empty = 1'b0;
    logic          m_ready = 1'b0;
    logic [DW-1:0] data_out = '0;
    logic          empty;
    logic          pop;
    logic          m_valid;
    logic          busy;
    logic [DW-1:0] m_data;
    logic [CW-1:0] word_cnt;
    logic [CW-1:0] err_cnt;

    logic [DW-1:0] fifo_mem [0:63];
    int            wr_idx = 0;
    int            rd_idx = 0;
    int            pop_total = 0;
    logic [DW-1:0] exp_q [$];
    int            errors = 0;
    int            checks = 0;
    bit            held = 1'b0;
    logic [DW-1:0] held_data = '0;

    always #5 clk = ~clk;

    fifo_rd_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk              (clk),
        .rst              (rst),
        .en               (en),
        .empty            (empty),
        .data_out         (data_out),
        .pop_err_on_empty (pop_err_on_empty),
        .pop              (pop),
        .m_valid          (m_valid),
        .m_data           (m_data),
        .m_ready          (m_ready),
        .busy             (busy),
        .word_cnt         (word_cnt),
        .err_cnt          (err_cnt)
    );

    // FIFO model: read data appears one cycle after pop; reset flushes remaining words.
    assign empty = (rd_idx == wr_idx);
    always @(posedge clk) begin
        if (rst) begin
            rd_idx <= wr_idx;
        end else if (pop) begin
            data_out  <= fifo_mem[rd_idx];
            rd_idx    <= rd_idx + 1;
            pop_total <= pop_total + 1;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held) begin
                checks++;
                if (!m_valid || m_data !== held_data) begin
                    errors++;
                    $display("FAIL hold: m_valid=%0b m_data=%0h required 1/%0h", m_valid, m_data, held_data);
                end
            end
            if (m_valid && m_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_extra: got word %0h, none expected", m_data);
                end else begin
                    if (m_data !== exp_q[0]) begin
                        errors++;
                        $display("FAIL sb_order: got %0h required %0h", m_data, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
            end
            if (pop) begin
                checks++;
                if (empty) begin
                    errors++;
                    $display("FAIL pop_when_empty: pop=1 with empty=1, required pop=0");
                end
            end
            held      = m_valid && !m_ready;
            held_data = m_data;
        end
    end

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [DW-1:0] d, input bit expect_it);
        fifo_mem[wr_idx] = d;
        wr_idx++;
        if (expect_it)
            exp_q.push_back(d);
    endtask

    task automatic do_reset();
        adv();
        rst = 1'b1; en = 1'b0; m_ready = 1'b0; pop_err_on_empty = 1'b0;
        smp();
        chk("rst_pop", pop, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_busy", busy, 0);
        adv();
        exp_q.delete();
        adv();
        rst = 1'b0;
        smp();
        chk("rst_word_cnt", word_cnt, 0);
        chk("rst_err_cnt", err_cnt, 0);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        smp();
        while (busy && n < 40) begin
            adv();
            smp();
            n++;
        end
        chk(name, busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int np0;
        int nv;
        int n;

        // basic fetch of a single word
        do_reset();
        adv(); push_word(8'hA5, 1'b1); en = 1'b1; m_ready = 1'b1;
        smp(); chk("t1_c0_pop", pop, 0);
        adv(); smp(); chk("t1_c1_pop", pop, 1);
        adv(); smp(); chk("t1_c2_valid", m_valid, 0);
        adv(); smp(); chk("t1_c3_valid", m_valid, 1); chk("t1_c3_data", m_data, 8'hA5);
        adv(); en = 1'b0; smp(); chk("t1_word_cnt", word_cnt, 1);
        wait_idle("t1_idle");
        chk("t1_sb_left", exp_q.size(), 0);

        // backpressure: two pops fill the buffer, then back-to-back delivery
        do_reset();
        adv();
        for (int i = 1; i <= 4; i++) push_word(DW'(i), 1'b1);
        en = 1'b1; m_ready = 1'b0; np0 = pop_total;
        repeat (6) adv();
        smp();
        chk("t2_pops", pop_total - np0, 2);
        chk("t2_valid", m_valid, 1);
        chk("t2_head", m_data, 8'h01);
        adv(); m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            smp();
            chk("t2_stream_valid", m_valid, 1);
            chk("t2_stream_data", m_data, i + 1);
            adv();
        end
        en = 1'b0;
        smp(); chk("t2_word_cnt", word_cnt, 4);
        wait_idle("t2_idle");
        chk("t2_sb_left", exp_q.size(), 0);

        // throughput: 8 words on 8 consecutive cycles
        do_reset();
        adv();
        for (int i = 0; i < 8; i++) push_word(DW'(8'h10 + i), 1'b1);
        en = 1'b1; m_ready = 1'b1;
        n = 0;
        smp();
        while (!m_valid && n < 20) begin adv(); smp(); n++; end
        chk("t3_first_valid", m_valid, 1);
        nv = 0;
        for (int i = 0; i < 8; i++) begin
            if (m_valid) nv++;
            adv();
            smp();
        end
        chk("t3_consecutive", nv, 8);
        chk("t3_word_cnt", word_cnt, 8);
        chk("t3_after_valid", m_valid, 0);
        adv(); en = 1'b0;
        wait_idle("t3_idle");
        chk("t3_sb_left", exp_q.size(), 0);

        // drain: en falls right after the first pop
        do_reset();
        adv();
        push_word(8'h21, 1'b1); push_word(8'h22, 1'b0); push_word(8'h23, 1'b0);
        en = 1'b1; m_ready = 1'b1; np0 = pop_total;
        adv(); smp(); chk("t4_c1_pop", pop, 1);
        adv(); en = 1'b0; smp(); chk("t4_c2_pop", pop, 0);
        wait_idle("t4_idle");
        chk("t4_pops", pop_total - np0, 1);
        chk("t4_word_cnt", word_cnt, 1);
        chk("t4_sb_left", exp_q.size(), 0);

        // empty FIFO with en high, plus three underflow pulses
        do_reset();
        adv(); en = 1'b1; m_ready = 1'b1; np0 = pop_total;
        for (int i = 0; i < 3; i++) begin
            adv(); pop_err_on_empty = 1'b1;
            adv(); pop_err_on_empty = 1'b0;
            adv();
        end
        smp();
        chk("t5_pops", pop_total - np0, 0);
        chk("t5_pop_now", pop, 0);
        chk("t5_busy", busy, 1);
        chk("t5_err_cnt", err_cnt, EXP_ERR);
        adv(); en = 1'b0;
        wait_idle("t5_idle");

        // reset mid-run with a full buffer
        do_reset();
        adv();
        for (int i = 0; i < 6; i++) push_word(DW'(8'h30 + i), 1'b1);
        en = 1'b1; m_ready = 1'b1;
        repeat (4) adv();
        m_ready = 1'b0;
        adv(); adv();
        smp();
        chk("t6_pre_word_cnt", word_cnt, 1);
        chk("t6_pre_valid", m_valid, 1);
        adv(); rst = 1'b1;
        smp();
        chk("t6_rst_valid", m_valid, 0);
        chk("t6_rst_pop", pop, 0);
        chk("t6_rst_busy", busy, 0);
        adv(); rst = 1'b0; en = 1'b0; exp_q.delete();
        smp();
        chk("t6_post_valid", m_valid, 0);
        chk("t6_post_word_cnt", word_cnt, 0);
        chk("t6_post_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
